// File: rtl/product_display_pkg.sv
// Shared types and constants for the product BCD display block.
// Latency: n/a (declarations and one combinational helper only).
// Backpressure: n/a.
package product_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 5;
  localparam int PRODUCT_W  = 16;
  localparam int BCD_W      = 20;
  localparam int SHREG_W    = BCD_W + PRODUCT_W;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // One double-dabble step: correct every BCD nibble that would overflow
  // on doubling (>= 5 gets +3), then shift the whole register left by one.
  function automatic logic [SHREG_W-1:0] dabble_step(input logic [SHREG_W-1:0] s);
    logic [SHREG_W-1:0] t;
    t = s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (t[PRODUCT_W + 4*i +: 4] >= 4'd5) begin
        t[PRODUCT_W + 4*i +: 4] = t[PRODUCT_W + 4*i +: 4] + 4'd3;
      end
    end
    return {t[SHREG_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_digit_to_seg.sv
// BCD digit to active-high seven-segment decoder (seg[6]=a ... seg[0]=g).
// Latency: combinational.
// Backpressure: none; codes 10-15 decode to blank.
module bcd_digit_to_seg
  import product_display_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Segment lookup for decimal digits; anything else stays dark.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0: o_seg = 7'b1111110;
      4'd1: o_seg = 7'b0110000;
      4'd2: o_seg = 7'b1101101;
      4'd3: o_seg = 7'b1111001;
      4'd4: o_seg = 7'b0110011;
      4'd5: o_seg = 7'b1011011;
      4'd6: o_seg = 7'b1011111;
      4'd7: o_seg = 7'b1110000;
      4'd8: o_seg = 7'b1111111;
      4'd9: o_seg = 7'b1111011;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/product_bcd_display.sv
// Captures the multiplier product on done_flag rise, converts to 5 BCD digits, scans a 5-digit display.
// Latency: bcd_valid 18 cycles after done_flag rises (1 capture + 16 shifts + 1 commit).
// Backpressure: none; a rise while busy is dropped. Optional LEADING_ZERO_BLANK_EN blanks leading zeros.
module product_bcd_display
  import product_display_pkg::*;
#(
  parameter int SCAN_DIV_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_a,
  input  logic                  done_flag,
  input  logic [PRODUCT_W-1:0]  product8_8,
  output logic [BCD_W-1:0]      bcd_out,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic [6:0]            seg
);

  logic                  r_done_d;
  state_t                r_state;
  logic [SHREG_W-1:0]    r_shreg;
  logic [3:0]            r_bit_cnt;
  logic [BCD_W-1:0]      r_bcd_out;
  logic                  r_bcd_valid;
  logic                  r_shown;
  logic [SCAN_DIV_W-1:0] r_pre;
  logic [2:0]            r_idx;
  logic [NUM_DIGITS-1:0] r_digit_en;
  logic [6:0]            r_seg;

  logic       w_edge;
  logic [3:0] w_nib;
  logic [2:0] w_msd;
  logic       w_blank;
  logic [6:0] w_seg_dec;

  // Edge detector keeps tracking while busy, so a held level never retriggers.
  assign w_edge = done_flag & ~r_done_d;

  // Delay done_flag by one cycle for rise detection.
  always_ff @(posedge clk) begin
    if (reset_a) r_done_d <= 1'b0;
    else         r_done_d <= done_flag;
  end

  // Capture / double-dabble / commit sequencer; result held until the next commit.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_bcd_out   <= '0;
      r_bcd_valid <= 1'b0;
      r_shown     <= 1'b0;
    end else begin
      r_bcd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_shreg   <= {{BCD_W{1'b0}}, product8_8};
            r_bit_cnt <= '0;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_shreg   <= dabble_step(r_shreg);
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd15) r_state <= DONE;
        end
        DONE: begin
          r_bcd_out   <= r_shreg[SHREG_W-1:PRODUCT_W];
          r_bcd_valid <= 1'b1;
          r_shown     <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Free-running refresh prescaler; the digit index steps on each wrap.
  always_ff @(posedge clk) begin
    if (reset_a) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
      if (&r_pre) r_idx <= (r_idx == 3'(NUM_DIGITS-1)) ? 3'd0 : r_idx + 3'd1;
    end
  end

  // Pick the scanned nibble and find the most-significant nonzero digit.
  always_comb begin
    w_nib = 4'd0;
    w_msd = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == 3'(i)) w_nib = r_bcd_out[4*i +: 4];
      if (r_bcd_out[4*i +: 4] != 4'd0) w_msd = 3'(i);
    end
`ifdef LEADING_ZERO_BLANK_EN
    // Digit 0 is never blanked because w_msd is at least 0.
    w_blank = (r_idx > w_msd);
`else
    w_blank = 1'b0;
`endif
  end

  bcd_digit_to_seg u_dec (
    .i_digit (w_nib),
    .o_seg   (w_seg_dec)
  );

  // Register digit select and segments together; dark until a result exists.
  always_ff @(posedge clk) begin
    if (reset_a || !r_shown) begin
      r_digit_en <= '0;
      r_seg      <= SEG_BLANK;
    end else begin
      r_digit_en <= NUM_DIGITS'(5'b00001 << r_idx);
      r_seg      <= w_blank ? SEG_BLANK : w_seg_dec;
    end
  end

  assign bcd_out   = r_bcd_out;
  assign bcd_valid = r_bcd_valid;
  assign busy      = (r_state != IDLE);
  assign digit_en  = r_digit_en;
  assign seg       = r_seg;

endmodule
